// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the fetch/data bus arbiter: FSM state encoding,
//   the state vector width, the timeout counter width and a small state
//   decode helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Width of the arbiter state vector.
    localparam int ARB_STATE_W = 3;

    // Timeout counter width; wide enough for the largest legal TIMEOUT (255).
    localparam int ARB_CNT_W = 8;

    // A fetch always reads a full word.
    localparam logic [3:0] ARB_SEL_ALL = 4'hF;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE     = 3'd0,
        ARB_BUSY_IF  = 3'd1,
        ARB_BUSY_MEM = 3'd2,
        ARB_ACK_IF   = 3'd3,
        ARB_ACK_MEM  = 3'd4
    } arb_state_t;

    // True while a bus cycle is in flight for either master.
    function automatic logic arb_is_busy(input arb_state_t s);
        return (s == ARB_BUSY_IF) || (s == ARB_BUSY_MEM);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Shares one external synchronous bus (wishbone-style cyc/ack) between the
//   instruction-fetch master and the data (load/store) master. One transfer
//   is in flight at a time; the data master has fixed priority over fetch so
//   the older instruction in the pipeline completes first. Every transfer
//   ends with a one-cycle ack to its owner, followed by a one-cycle bus gap.
//   A transfer whose slave does not answer within TIMEOUT busy cycles is
//   aborted: the owner still gets its ack (with zero read data) and err
//   pulses alongside it.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  busy cycles without bus_ack_i before abort (1..255)
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req_i / if_addr_i     fetch request and address (req held until ack)
//   if_rdata_o / if_ack_o    fetched word and its one-cycle ack
//   mem_req_i, mem_we_i,     data request, write enable, byte enables,
//   mem_sel_i, mem_addr_i,   address and store data (req held until ack)
//   mem_wdata_i
//   mem_rdata_o / mem_ack_o  load data and its one-cycle ack
//   bus_cyc_o, bus_we_o,     registered bus request side
//   bus_sel_o, bus_addr_o,
//   bus_wdata_o
//   bus_rdata_i, bus_ack_i   slave response
//   stallreq_o               combinational stall request to the pipeline ctrl
//   err_o                    one-cycle pulse on timeout abort
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,

    output logic              bus_cyc_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,

    output logic              stallreq_o,
    output logic              err_o
);

    // Counter value on the last busy cycle before the abort. The counter
    // starts at 0 on the first busy cycle, so reaching TIMEOUT-1 without an
    // ack means TIMEOUT busy cycles have elapsed.
    localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT - 1);

    arb_state_t           state_reg;
    logic [ARB_CNT_W-1:0] cnt_reg;

    logic                 bus_cyc_reg;
    logic                 bus_we_reg;
    logic [3:0]           bus_sel_reg;
    logic [ADDR_W-1:0]    bus_addr_reg;
    logic [DATA_W-1:0]    bus_wdata_reg;

    logic [DATA_W-1:0]    if_rdata_reg;
    logic [DATA_W-1:0]    mem_rdata_reg;
    logic                 if_ack_reg;
    logic                 mem_ack_reg;
    logic                 err_reg;

    // Which master owns the current busy state (only meaningful while busy).
    logic                 owner_is_mem;
    assign owner_is_mem = (state_reg == ARB_BUSY_MEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            cnt_reg       <= '0;
            bus_cyc_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_sel_reg   <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            mem_ack_reg   <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            // Acks and err are single-cycle pulses unless re-armed below.
            if_ack_reg  <= 1'b0;
            mem_ack_reg <= 1'b0;
            err_reg     <= 1'b0;

            if (state_reg == ARB_IDLE) begin
                cnt_reg <= '0;
                // Data first: the load/store belongs to an older instruction
                // than the one being fetched.
                if (mem_req_i) begin
                    state_reg     <= ARB_BUSY_MEM;
                    bus_cyc_reg   <= 1'b1;
                    bus_we_reg    <= mem_we_i;
                    bus_sel_reg   <= mem_sel_i;
                    bus_addr_reg  <= mem_addr_i;
                    bus_wdata_reg <= mem_wdata_i;
                end else if (if_req_i) begin
                    state_reg     <= ARB_BUSY_IF;
                    bus_cyc_reg   <= 1'b1;
                    bus_we_reg    <= 1'b0;
                    bus_sel_reg   <= ARB_SEL_ALL;
                    bus_addr_reg  <= if_addr_i;
                    bus_wdata_reg <= '0;
                end
            end else if (arb_is_busy(state_reg)) begin
                // The request lines are deliberately not looked at here: a
                // master that withdraws mid-transfer still gets its ack,
                // since a store may already have reached the slave.
                if (bus_ack_i) begin
                    // A slave ack wins over a timeout on the same cycle.
                    bus_cyc_reg <= 1'b0;
                    bus_we_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    if (owner_is_mem) begin
                        mem_rdata_reg <= bus_rdata_i;
                        mem_ack_reg   <= 1'b1;
                        state_reg     <= ARB_ACK_MEM;
                    end else begin
                        if_rdata_reg  <= bus_rdata_i;
                        if_ack_reg    <= 1'b1;
                        state_reg     <= ARB_ACK_IF;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    // Abort: release the bus, hand back zero data and flag it.
                    bus_cyc_reg <= 1'b0;
                    bus_we_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    err_reg     <= 1'b1;
                    if (owner_is_mem) begin
                        mem_rdata_reg <= '0;
                        mem_ack_reg   <= 1'b1;
                        state_reg     <= ARB_ACK_MEM;
                    end else begin
                        if_rdata_reg  <= '0;
                        if_ack_reg    <= 1'b1;
                        state_reg     <= ARB_ACK_IF;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                // ACK_IF / ACK_MEM (and any illegal code): requests are not
                // sampled here, which gives the one-cycle gap between
                // back-to-back transfers and keeps a still-high req from
                // being mistaken for a new one.
                state_reg <= ARB_IDLE;
                cnt_reg   <= '0;
            end
        end
    end

    assign bus_cyc_o   = bus_cyc_reg;
    assign bus_we_o    = bus_we_reg;
    assign bus_sel_o   = bus_sel_reg;
    assign bus_addr_o  = bus_addr_reg;
    assign bus_wdata_o = bus_wdata_reg;
    assign if_rdata_o  = if_rdata_reg;
    assign mem_rdata_o = mem_rdata_reg;
    assign if_ack_o    = if_ack_reg;
    assign mem_ack_o   = mem_ack_reg;
    assign err_o       = err_reg;

    // Stall while any master has an outstanding request; it clears in the
    // ack cycle so the pipeline can advance on the same edge the data lands.
    assign stallreq_o = (mem_req_i & ~mem_ack_reg) | (if_req_i & ~if_ack_reg);

endmodule
